bin_to_bcd_seq: RTL and testbench

//  Sequential binary-to-BCD converter (shift-add-3 / double-dabble), one bit per clock.

---
 rtl/bin_to_bcd_seq.sv | 121 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq
// Brief    : Sequential shift-add-3 binary-to-BCD converter, one bit per clock.
// Revision : 1.0
// ============================================================================
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      binIn,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcdOut,
    output logic                  neg,
    output logic                  overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 4 * DIGITS;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [WIDTH-1:0] r_mag;
    logic [SW-1:0]    r_scratch;
    logic [CW-1:0]    r_count;
    logic             r_sign;
    logic             r_ovf;

    logic [SW-1:0]    w_adj;
    logic [SW-1:0]    w_scratch_next;
    logic [WIDTH-1:0] w_mag_next;
    logic             w_ovf_bit;
    logic             w_ovf_next;
    logic             w_last;
    logic             w_accept;
    logic             w_neg_in;
    logic [WIDTH-1:0] w_abs;

    // Every nibble is corrected from its pre-add value, all in parallel.
    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_adj
            assign w_adj[4*d +: 4] = (r_scratch[4*d +: 4] >= 4'd5)
                                   ? r_scratch[4*d +: 4] + 4'd3
                                   : r_scratch[4*d +: 4];
        end
    endgenerate

    // The bit pushed out of the top nibble means a dropped upper digit.
    assign {w_ovf_bit, w_scratch_next, w_mag_next} = {w_adj, r_mag, 1'b0};
    assign w_ovf_next = r_ovf | w_ovf_bit;

    assign w_last   = (r_count == CW'(1));
    assign w_accept = (r_state == IDLE) && start;
    assign w_neg_in = (SIGNED != 0) && binIn[WIDTH-1];
    assign w_abs    = w_neg_in ? -binIn : binIn;
    assign busy     = (r_state == SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = SHIFT;
            SHIFT:   if (w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mag     <= '0;
            r_scratch <= '0;
            r_count   <= '0;
            r_sign    <= 1'b0;
            r_ovf     <= 1'b0;
            bcdOut    <= '0;
            neg       <= 1'b0;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                r_mag     <= w_abs;
                r_sign    <= w_neg_in;
                r_scratch <= '0;
                r_ovf     <= 1'b0;
                r_count   <= CW'(WIDTH);
            end else if (r_state == SHIFT) begin
                r_mag     <= w_mag_next;
                r_scratch <= w_scratch_next;
                r_ovf     <= w_ovf_next;
                r_count   <= r_count - CW'(1);
                if (w_last) begin
                    bcdOut   <= w_scratch_next;
                    neg      <= r_sign;
                    overflow <= w_ovf_next;
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd_seq
// Brief    : Directed bench for bin_to_bcd_seq in three parameterisations.
// Revision : 1.0
// ============================================================================
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  binIn;

    logic        busy0, done0, neg0, ovf0;
    logic [11:0] bcd0;
    logic        busy1, done1, neg1, ovf1;
    logic [11:0] bcd1;
    logic        busy2, done2, neg2, ovf2;
    logic [7:0]  bcd2;

    int checks = 0;
    int errors = 0;
    int lat;
    int pulses;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .binIn(binIn),
        .busy(busy0), .done(done0), .bcdOut(bcd0), .neg(neg0), .overflow(ovf0));

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .binIn(binIn),
        .busy(busy1), .done(done1), .bcdOut(bcd1), .neg(neg1), .overflow(ovf1));

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2), .SIGNED(0)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .binIn(binIn),
        .busy(busy2), .done(done2), .bcdOut(bcd2), .neg(neg2), .overflow(ovf2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called right after the accepting edge; returns clocks until done.
    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
            if (!done0) chk("busy_during", {31'd0, busy0}, 32'd1);
        end while (!done0 && cnt < 30);
        chk("latency", cnt, 32'd8);
        chk("busy_in_done", {31'd0, busy0}, 32'd0);
        chk("done_sync", {29'd0, done0, done1, done2}, 32'd7);
    endtask

    task automatic accept(input logic [7:0] v);
        @(negedge clk);
        binIn = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_all(input string tag,
                             input logic [11:0] e0,
                             input logic [11:0] e1, input logic n1,
                             input logic [7:0]  e2, input logic o2);
        chk({tag, "_bcd0"}, {20'd0, bcd0}, {20'd0, e0});
        chk({tag, "_flags0"}, {30'd0, neg0, ovf0}, 32'd0);
        chk({tag, "_bcd1"}, {20'd0, bcd1}, {20'd0, e1});
        chk({tag, "_flags1"}, {30'd0, neg1, ovf1}, {30'd0, n1, 1'b0});
        chk({tag, "_bcd2"}, {24'd0, bcd2}, {24'd0, e2});
        chk({tag, "_flags2"}, {30'd0, neg2, ovf2}, {30'd0, 1'b0, o2});
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        binIn = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {29'd0, busy0, busy1, busy2}, 32'd0);
        chk("rst_done", {29'd0, done0, done1, done2}, 32'd0);
        check_all("rst", 12'h000, 12'h000, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;

        // T1: 255 -> signed view is -1, two-digit view overflows
        accept(8'd255);
        chk("t1_busy_e0", {31'd0, busy0}, 32'd1);
        chk("t1_hold", {20'd0, bcd0}, 32'h000);
        wait_done(lat);
        check_all("t1", 12'h255, 12'h001, 1'b1, 8'h55, 1'b1);
        @(posedge clk);
        #1;
        chk("t1_done_pulse", {31'd0, done0}, 32'd0);
        chk("t1_stable", {20'd0, bcd0}, 32'h255);

        // T2: 0xD6 = 214 / -42, and 0x80 = 128 / -128
        accept(8'hD6);
        wait_done(lat);
        check_all("t2a", 12'h214, 12'h042, 1'b1, 8'h14, 1'b1);
        accept(8'h80);
        wait_done(lat);
        check_all("t2b", 12'h128, 12'h128, 1'b1, 8'h28, 1'b1);

        // T3: truncation boundary for two digits, plus zero
        accept(8'd123);
        wait_done(lat);
        check_all("t3a", 12'h123, 12'h123, 1'b0, 8'h23, 1'b1);
        accept(8'd99);
        wait_done(lat);
        check_all("t3b", 12'h099, 12'h099, 1'b0, 8'h99, 1'b0);
        accept(8'd0);
        wait_done(lat);
        check_all("t3c", 12'h000, 12'h000, 1'b0, 8'h00, 1'b0);

        // T4: start pulsed mid-conversion is ignored
        accept(8'd7);
        @(negedge clk);
        @(negedge clk);
        binIn = 8'd200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done0) pulses++;
        end
        chk("t4_pulses", pulses, 32'd1);
        check_all("t4", 12'h007, 12'h007, 1'b0, 8'h07, 1'b0);

        // T5: reset aborts a running conversion
        accept(8'd255);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t5_busy", {29'd0, busy0, busy1, busy2}, 32'd0);
        chk("t5_done", {29'd0, done0, done1, done2}, 32'd0);
        check_all("t5_rst", 12'h000, 12'h000, 1'b0, 8'h00, 1'b0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done0) pulses++;
        end
        chk("t5_no_done", pulses, 32'd0);
        accept(8'd9);
        wait_done(lat);
        check_all("t5", 12'h009, 12'h009, 1'b0, 8'h09, 1'b0);

        // T6: start held high, alternating operands, one conversion per 9 clocks
        @(negedge clk);
        binIn = 8'd10;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            wait_done(lat);
            if (k % 2 == 0)
                check_all("t6_ten", 12'h010, 12'h010, 1'b0, 8'h10, 1'b0);
            else
                check_all("t6_zero", 12'h000, 12'h000, 1'b0, 8'h00, 1'b0);
            @(negedge clk);
            binIn = (k % 2 == 0) ? 8'd0 : 8'd10;
            @(posedge clk);
            #1;
            chk("t6_reaccept", {31'd0, busy0}, 32'd1);
        end
        start = 1'b0;
        repeat (12) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
